// File: rtl/seg_pkg.sv
// seg_pkg: glyph constants, internal code values and the digit segment table
// shared by the seven-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Internal codes used above 9; user codes 10..15 are folded to BCD_BLANK.
  localparam logic [3:0] BCD_MINUS = 4'd10;
  localparam logic [3:0] BCD_BLANK = 4'd11;

  // Common-anode g..a pattern for a decimal digit (active-low segments).
  function automatic logic [6:0] seg_digit_pat(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// seg_glyph_dec: combinational code + decimal point to active-low segment byte.
// Codes 0..9 are digits, BCD_MINUS is the minus glyph, anything else is blank.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] glyph
);

  // Digit table lookup; the point only lights on real digits.
  always_comb begin
    glyph = SEG_BLANK;
    if (code <= 4'd9) begin
      glyph = {~dp, seg_digit_pat(code)};
    end else if (code == BCD_MINUS) begin
      glyph = SEG_MINUS;
    end
  end

endmodule

// File: rtl/seg_dyn_scan.sv
// seg_dyn_scan: multiplexed common-anode seven-segment scanner with leading-zero
// blanking, floating sign, PWM brightness and frame-synchronous updates.
// Optional feature: define SEG_DYN_BLINK_EN to enable per-digit blinking.
module seg_dyn_scan
  import seg_pkg::*;
#(
  parameter int N_DIG        = 8,
  parameter int SLOT_CYC     = 50000,
  parameter int BR_W         = 3,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [4*N_DIG-1:0]   bcd_in,
  input  logic [N_DIG-1:0]     point,
  input  logic                 sign,
  input  logic                 lzb_en,
  input  logic [N_DIG-1:0]     blink_mask,
  input  logic                 upd_vld,
  output logic                 upd_rdy,
  input  logic                 seg_en,
  input  logic [BR_W-1:0]      bright,
  output logic [N_DIG-1:0]     sel,
  output logic [7:0]           seg,
  output logic                 frame_start,
  output logic                 sign_ovf
);

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam int DIG_W = $clog2(N_DIG);
  localparam int STEP  = SLOT_CYC >> BR_W;

  logic [CNT_W-1:0]   slot_cnt;
  logic [DIG_W-1:0]   dig_idx;
  logic               slot_wrap;
  logic               frame_bnd;

  logic [4*N_DIG-1:0] pend_bcd, act_bcd;
  logic [N_DIG-1:0]   pend_pt, act_pt;
  logic [N_DIG-1:0]   pend_blink, act_blink;
  logic               pend_sign, act_sign;
  logic               pend_full;

  logic [N_DIG-1:0]   lz_blank;
  logic [N_DIG-1:0]   sign_hit;
  logic               chain;
  logic               found;
  logic               ovf_nxt;
  logic [3:0]         cur_code;
  logic               cur_dp;
  logic               cur_blink;
  logic [7:0]         glyph;
  logic [CNT_W:0]     pwm_thr;
  logic               pwm_on;
  logic               blink_phase;

  assign slot_wrap = (slot_cnt == CNT_W'(SLOT_CYC - 1));
  assign frame_bnd = slot_wrap && (dig_idx == DIG_W'(N_DIG - 1));
  assign upd_rdy   = ~pend_full;

  // Slot timer and digit index; the frame boundary is the wrap back to digit 0.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == DIG_W'(N_DIG - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Pending buffer takes one offer; it moves to the active set only at a frame boundary.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_bcd   <= '0;
      pend_pt    <= '0;
      pend_blink <= '0;
      pend_sign  <= 1'b0;
      pend_full  <= 1'b0;
      act_bcd    <= '0;
      act_pt     <= '0;
      act_blink  <= '0;
      act_sign   <= 1'b0;
    end else begin
      if (frame_bnd && pend_full) begin
        act_bcd   <= pend_bcd;
        act_pt    <= pend_pt;
        act_blink <= pend_blink;
        act_sign  <= pend_sign;
        pend_full <= 1'b0;
      end
      // Accept is gated by the old pending state, so it never collides with the copy.
      if (upd_vld && !pend_full) begin
        pend_bcd   <= bcd_in;
        pend_pt    <= point;
        pend_blink <= blink_mask;
        pend_sign  <= sign;
        pend_full  <= 1'b1;
      end
    end
  end

  // Blanking, sign placement and selection of the code for the scanned digit.
  always_comb begin
    chain     = 1'b1;
    found     = 1'b0;
    lz_blank  = '0;
    sign_hit  = '0;
    cur_code  = BCD_BLANK;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      chain       = chain & (act_bcd[4*k +: 4] == 4'd0) & ~act_pt[k];
      lz_blank[k] = lzb_en && (k != 0) && chain;
    end
    // Blanked digits form a contiguous top run, so its lowest member sits just above the MSD.
    for (int k = 1; k < N_DIG; k++) begin
      if (lz_blank[k] && !found) begin
        sign_hit[k] = 1'b1;
        found       = 1'b1;
      end
    end
    ovf_nxt = act_sign & ~found;
    for (int k = 0; k < N_DIG; k++) begin
      if (dig_idx == DIG_W'(k)) begin
        cur_code  = (act_bcd[4*k +: 4] > 4'd9) ? BCD_BLANK : act_bcd[4*k +: 4];
        cur_dp    = act_pt[k];
        cur_blink = act_blink[k];
        if (lz_blank[k]) begin
          cur_code = BCD_BLANK;
          cur_dp   = 1'b0;
        end
        if (act_sign && sign_hit[k]) begin
          cur_code = BCD_MINUS;
          cur_dp   = 1'b0;
        end
      end
    end
  end

  seg_glyph_dec u_glyph (
    .code  (cur_code),
    .dp    (cur_dp),
    .glyph (glyph)
  );

  // Brightness gates sel for the first bright/2^BR_W of the slot; all-ones means full slot.
  assign pwm_thr = (CNT_W + 1)'(int'(bright) * STEP);
  assign pwm_on  = (&bright) || ({1'b0, slot_cnt} < pwm_thr);

`ifdef SEG_DYN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0] blink_cnt;

  // Frame down-counter toggles the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_cnt   <= BF_W'(BLINK_FRAMES - 1);
      blink_phase <= 1'b0;
    end else if (frame_bnd) begin
      if (blink_cnt == '0) begin
        blink_cnt   <= BF_W'(BLINK_FRAMES - 1);
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end
`else
  // Blink not built: phase is constant 0 and BLINK_FRAMES has no effect.
  assign blink_phase = (BLINK_FRAMES < 0);
`endif

  // Registered outputs, one cycle behind the counter state they describe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel         <= '0;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
      sign_ovf    <= 1'b0;
    end else begin
      frame_start <= (slot_cnt == '0) && (dig_idx == '0);
      sign_ovf    <= ovf_nxt;
      if (seg_en) begin
        sel <= pwm_on ? (N_DIG'(1) << dig_idx) : '0;
        seg <= (blink_phase && cur_blink) ? SEG_BLANK : glyph;
      end else begin
        sel <= '0;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_dyn_scan.sv
// tb_seg_dyn_scan: directed bench for seg_dyn_scan (6 digits, 16-cycle slots).
module tb_seg_dyn_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [23:0] bcd_in = '0;
  logic [5:0]  point = '0;
  logic        sign = 1'b0;
  logic        lzb_en = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic        upd_vld = 1'b0;
  logic        upd_rdy;
  logic        seg_en = 1'b1;
  logic [1:0]  bright = 2'd3;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_start;
  logic        sign_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] seen [6];
  int cnt;

  seg_dyn_scan #(.N_DIG(6), .SLOT_CYC(16), .BR_W(2), .BLINK_FRAMES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bcd_in      (bcd_in),
    .point       (point),
    .sign        (sign),
    .lzb_en      (lzb_en),
    .blink_mask  (blink_mask),
    .upd_vld     (upd_vld),
    .upd_rdy     (upd_rdy),
    .seg_en      (seg_en),
    .bright      (bright),
    .sel         (sel),
    .seg         (seg),
    .frame_start (frame_start),
    .sign_ovf    (sign_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!frame_start && n < 200);
    if (!frame_start) chk("fs_timeout", 0, 1);
  endtask

  // Called at a frame_start negedge: sample each digit's slot.
  task automatic grab();
    seen[0] = seg;
    for (int k = 1; k < 6; k++) begin
      repeat (16) @(negedge sys_clk);
      seen[k] = seg;
    end
  endtask

  task automatic load(input logic [23:0] v, input logic [5:0] p, input logic s,
                      input logic [5:0] bm);
    int n = 0;
    while (!upd_rdy && n < 300) begin @(negedge sys_clk); n++; end
    if (!upd_rdy) chk("rdy_timeout_a", 0, 1);
    bcd_in = v; point = p; sign = s; blink_mask = bm; upd_vld = 1'b1;
    @(negedge sys_clk);
    upd_vld = 1'b0;
    n = 0;
    while (!upd_rdy && n < 300) begin @(negedge sys_clk); n++; end
    if (!upd_rdy) chk("rdy_timeout_b", 0, 1);
    wait_fs();
    grab();
  endtask

  task automatic count_sel0(output int c);
    c = 0;
    wait_fs();
    for (int i = 0; i < 16; i++) begin
      if (sel[0]) c++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", sel, 6'h00);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_rdy", upd_rdy, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_ovf", sign_ovf, 0);

    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("first_fs", frame_start, 1);
    chk("walk_sel0", sel, 6'h01);
    chk("rst_d0", seg, 8'hC0);
    @(negedge sys_clk);
    chk("fs_pulse", frame_start, 0);
    repeat (15) @(negedge sys_clk);
    for (int k = 1; k < 6; k++) begin
      chk($sformatf("walk_sel%0d", k), sel, 6'h01 << k);
      repeat (16) @(negedge sys_clk);
    end

    lzb_en = 1'b1;
    load(24'h001234, 6'b000000, 1'b1, 6'b0);
    chk("v1234_d0", seen[0], 8'h99);
    chk("v1234_d1", seen[1], 8'hB0);
    chk("v1234_d2", seen[2], 8'hA4);
    chk("v1234_d3", seen[3], 8'hF9);
    chk("v1234_d4", seen[4], 8'hBF);
    chk("v1234_d5", seen[5], 8'hFF);
    chk("v1234_ovf", sign_ovf, 0);

    load(24'h999999, 6'b000000, 1'b1, 6'b0);
    for (int k = 0; k < 6; k++) chk($sformatf("v9_d%0d", k), seen[k], 8'h90);
    chk("v9_ovf", sign_ovf, 1);

    load(24'h000005, 6'b000100, 1'b0, 6'b0);
    chk("pt_d0", seen[0], 8'h92);
    chk("pt_d1", seen[1], 8'hC0);
    chk("pt_d2", seen[2], 8'h40);
    chk("pt_d3", seen[3], 8'hFF);
    chk("pt_d4", seen[4], 8'hFF);
    chk("pt_d5", seen[5], 8'hFF);
    chk("pt_ovf", sign_ovf, 0);

    // Mid-frame offer, then a second one held against a full pending buffer.
    wait_fs();
    repeat (20) @(negedge sys_clk);
    bcd_in = 24'h000007; point = '0; sign = 1'b0; upd_vld = 1'b1;
    @(negedge sys_clk);
    chk("rdy_drop", upd_rdy, 0);
    bcd_in = 24'h000008;
    repeat (5) @(negedge sys_clk);
    chk("stall", upd_rdy, 0);
    repeat (10) @(negedge sys_clk);
    chk("old_frame_d2", seg, 8'h40);
    wait_fs();
    chk("new_d0", seg, 8'hF8);
    chk("second_taken", upd_rdy, 0);
    upd_vld = 1'b0;
    wait_fs();
    chk("third_d0", seg, 8'h80);

    bright = 2'd1;
    count_sel0(cnt);
    chk("pwm_b1", cnt, 4);
    bright = 2'd0;
    count_sel0(cnt);
    chk("pwm_b0", cnt, 0);
    bright = 2'd3;
    count_sel0(cnt);
    chk("pwm_b3", cnt, 16);

    seg_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("off_sel", sel, 6'h00);
    chk("off_seg", seg, 8'hFF);
    seg_en = 1'b1;

    // Reset while an update is pending.
    bcd_in = 24'h000003; upd_vld = 1'b1;
    @(negedge sys_clk);
    upd_vld = 1'b0;
    chk("pend_full", upd_rdy, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_rdy", upd_rdy, 1);
    chk("mid_rst_sel", sel, 6'h00);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_fs", frame_start, 1);
    chk("mid_rst_d0", seg, 8'hC0);

`ifdef SEG_DYN_BLINK_EN
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    bcd_in = 24'h000005; point = '0; sign = 1'b0; blink_mask = 6'b000001; upd_vld = 1'b1;
    @(negedge sys_clk);
    upd_vld = 1'b0;
    wait_fs();
    chk("blink_f1", seg, 8'h92);
    wait_fs();
    chk("blink_f2", seg, 8'hFF);
    wait_fs();
    chk("blink_f3", seg, 8'hFF);
    wait_fs();
    chk("blink_f4", seg, 8'h92);
    wait_fs();
    chk("blink_f5", seg, 8'h92);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
